// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants, glyph table and spinner types
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high a..g patterns for hex digits 0-F (b and d in lower case form)
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Rotation animation steps: a, f, e, d, c, b
    localparam logic [6:0] SPIN_SEQ [6] = '{
        7'h01, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02
    };

    // SPIN_Sk means step k-1 of SPIN_SEQ has been seen
    typedef enum logic [2:0] {
        SPIN_IDLE = 3'd0,
        SPIN_S1   = 3'd1,
        SPIN_S2   = 3'd2,
        SPIN_S3   = 3'd3,
        SPIN_S4   = 3'd4,
        SPIN_S5   = 3'd5
    } spin_state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational active-high a..g pattern to hex nibble decoder
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_bus_monitor.sv
// rtl/seg_bus_monitor.sv - receive-side monitor for a multiplexed 4-digit seven-segment bus
// Optional spinner tracker built when SEG_SPIN_DETECT_EN is defined.
module seg_bus_monitor
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SPIN_DIGIT    = 3
) (
    input  logic        inclk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  en_in,
    output logic [15:0] digit_val,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_dp,
    output logic        capture,
    output logic        conflict,
    output logic        spin_rev,
    output logic [7:0]  spin_count
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [11:0] sync1, sync2, prev;
    logic        ok1, ok2, ok3;
    logic [7:0]  cnt, cnt_nxt;
    logic        fire;
    logic [7:0]  s_seg;
    logic [3:0]  en_low;
    logic        multi, one_hot;
    logic [1:0]  idx;
    logic [6:0]  pat;
    logic        hit;
    logic [3:0]  nib;

    assign s_seg   = sync2[7:0];
    assign en_low  = ~sync2[11:8];
    assign pat     = ~s_seg[6:0];
    assign multi   = (en_low & (en_low - 4'd1)) != 4'd0;
    assign one_hot = (en_low != 4'd0) && !multi;

    seg_glyph_decode u_decode (
        .pattern (pat),
        .hit     (hit),
        .nibble  (nib)
    );

    // ok3 holds the reload until both prev and S carry post-reset bus data
    always_comb begin
        cnt_nxt = cnt;
        if (!ok3 || (sync2 != prev)) begin
            cnt_nxt = 8'd0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + 8'd1;
        end
    end

    assign fire = (cnt_nxt == CNT_MAX) && (cnt != CNT_MAX);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (en_low[i]) begin
                idx = 2'(i);
            end
        end
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            ok1         <= 1'b0;
            ok2         <= 1'b0;
            ok3         <= 1'b0;
            cnt         <= '0;
            digit_val   <= '0;
            digit_valid <= '0;
            digit_dp    <= '0;
            capture     <= 1'b0;
            conflict    <= 1'b0;
        end else begin
            sync1    <= {en_in, seg_in};
            sync2    <= sync1;
            prev     <= sync2;
            ok1      <= 1'b1;
            ok2      <= ok1;
            ok3      <= ok2;
            cnt      <= cnt_nxt;
            capture  <= 1'b0;
            conflict <= 1'b0;
            if (fire) begin
                if (one_hot) begin
                    capture          <= 1'b1;
                    digit_dp[idx]    <= ~s_seg[SEG_DP];
                    digit_valid[idx] <= hit;
                    if (hit) begin
                        digit_val[{idx, 2'b00} +: 4] <= nib;
                    end
                end else if (multi) begin
                    conflict <= 1'b1;
                end
            end
        end
    end

`ifdef SEG_SPIN_DETECT_EN
    spin_state_t spin_st;
    logic [2:0]  cur_idx, nxt_idx;
    logic        spin_hit;

    assign spin_hit = fire && one_hot && (idx == 2'(SPIN_DIGIT));
    assign nxt_idx  = spin_st;
    assign cur_idx  = nxt_idx - 3'd1;

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            spin_st    <= SPIN_IDLE;
            spin_rev   <= 1'b0;
            spin_count <= '0;
        end else begin
            spin_rev <= 1'b0;
            if (spin_hit) begin
                if (spin_st == SPIN_IDLE) begin
                    if (pat == SPIN_SEQ[0]) begin
                        spin_st <= SPIN_S1;
                    end
                end else if (pat != SPIN_SEQ[cur_idx]) begin
                    if (pat == SPIN_SEQ[nxt_idx]) begin
                        if (spin_st == SPIN_S5) begin
                            spin_rev   <= 1'b1;
                            spin_count <= spin_count + 8'd1;
                            spin_st    <= SPIN_IDLE;
                        end else begin
                            spin_st <= spin_state_t'(nxt_idx + 3'd1);
                        end
                    end else begin
                        spin_st <= (pat == SPIN_SEQ[0]) ? SPIN_S1 : SPIN_IDLE;
                    end
                end
            end
        end
    end
`else
    assign spin_rev   = 1'b0;
    assign spin_count = 8'd0;
`endif

endmodule
